peak_level_meter: RTL and testbench
===================================

Name: peak_level_meter

Overview:
- Streaming level monitor downstream of the FIR stage.
- Consumes each filtered sample on the FIR done strobe and produces a held, decaying peak magnitude.
- Also raises a sticky clip indication with a saturating clip counter, for status readout and LED drive.
- Uses the same clock domain and sample width as the FIR and I2S datapath; it never stalls the stream.

Parameters:
- DataWidth, 12, width of the signed two's-complement input sample.
- HoldSamples, 4, number of valid samples the peak is held before decay starts (0 means no hold).
- DecayShift, 3, decay step is peak>>DecayShift per valid sample, minimum step 1.
- ClipCountWidth, 8, width of the saturating clip counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sampleIn  input  DataWidth  signed filtered sample; sampled only when sampleValid=1
- sampleValid  input  1  one-cycle strobe from the FIR done output
- clear  input  1  synchronous clear of all meter state
- peak  output  DataWidth-1  unsigned held/decayed peak magnitude
- peakValid  output  1  one-cycle pulse when peak has been updated for a sample
- clipFlag  output  1  sticky; set when any full-scale sample is seen
- clipCount  output  ClipCountWidth  saturating count of full-scale samples

Behaviour:
- Reset (async, active-high): peak=0, peakValid=0, clipFlag=0, clipCount=0, hold counter=0, state=IDLE, pipeline valid=0.
- Stage 1 (registered, on sampleValid):
  - mag = |sampleIn|; the most-negative code saturates to 2^(DataWidth-1)-1 (-2048 gives 2047).
  - isClip = (sampleIn == max positive code) or (sampleIn == min negative code).
- Stage 2: updates peak, hold and clip state. peakValid pulses in that same cycle, so latency is 2 cycles from the sampleValid edge. Back-to-back sampleValid is supported at 1 sample/cycle.
- FSM states: IDLE (peak=0), HOLD (hold counter>0), DECAY (hold counter=0, peak>0). Per stage-2 sample:
  - If mag >= peak and mag > 0: peak<=mag, hold<=HoldSamples, state<=HOLD. If HoldSamples=0, state<=DECAY instead.
  - Else in HOLD: hold<=hold-1, peak unchanged. State goes to DECAY when hold reaches 0.
  - Else in DECAY: d = peak - max(peak>>DecayShift, 1); peak<=max(d, mag); hold not reloaded. State goes to IDLE when the new peak = 0.
  - In IDLE with mag=0: no change, but peakValid still pulses.
- The state only changes on stage-2 samples; no time-based decay between samples.
- Clip handling: when isClip, clipFlag<=1 and clipCount<=clipCount+1, saturating at 2^ClipCountWidth-1 with no wrap.
- clear:
  - Next edge sets peak, hold, clipFlag, clipCount and state to reset values.
  - Flushes both pipeline stages, so no peakValid is produced for samples in flight or arriving in that cycle.
  - clear has priority over everything else.
- Async reset mid-pipeline discards the in-flight sample; the first peakValid after reset belongs to the first post-reset sampleValid.
- Arithmetic:
  - All magnitude math is unsigned DataWidth-1 bits.
  - The decay subtraction never underflows because the step is at most peak.
  - Compare mag >= peak: equal magnitudes reload the hold counter.

Decomposition:
- Package meter_pkg holds:
  - the state enum (IDLE, HOLD, DECAY);
  - the MagWidth = DataWidth-1 localparam convention;
  - the full-scale code constants as functions of DataWidth.
- One sub-module, sample_magnitude: registered stage 1 producing mag, isClip and a valid flag. It is independently testable for the saturation corner.

Test Plan (DataWidth=12, HoldSamples=4, DecayShift=3):
- Reset with no samples -> peak=0, peakValid=0, clipFlag=0, clipCount=0; assert reset mid-pipeline -> outputs 0 immediately, no stray peakValid.
- sampleValid with 1000, then -1500 on consecutive cycles -> peak=1000 then 1500; peakValid pulses exactly 2 cycles after each strobe.
- Hold and decay:
  - After peak=1500, send 0 six times.
  - Samples 1-4 -> peak stays 1500.
  - Sample 5 -> 1313; sample 6 -> 1149.
- Clip detection:
  - Send -2048 -> peak=2047, clipFlag=1, clipCount=1.
  - Then send 2047 -> clipCount=2, peak=2047 with hold reloaded.
  - Send 300 full-scale samples -> clipCount saturates at 255.
- Decay to zero: peak=5 in DECAY, send zeros -> 4, 3, 2, 1, 0 (minimum step 1), state IDLE; further zeros keep peak 0 with peakValid pulses.
- clear asserted in the same cycle as sampleValid=1800, with one sample in stage 1 -> all state 0, no peakValid for either sample; the next sample 200 -> peak=200 after 2 cycles.

Source files
------------

// File: rtl/meter_pkg.sv
// ---------------------------------------------------------------------------
// meter_pkg
// Shared definitions for the peak level meter:
//   - meter_state_e : peak tracker state (IDLE, HOLD, DECAY)
//   - mag_width()   : magnitude width convention (DataWidth-1 bits)
//   - max_pos_code(), min_neg_code() : full-scale two's-complement codes,
//     returned as 32-bit patterns to be truncated to DataWidth by the user.
// ---------------------------------------------------------------------------
package meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } meter_state_e;

    // Magnitudes drop the sign bit; the most-negative code saturates.
    function automatic int mag_width(input int data_width);
        return data_width - 1;
    endfunction

    function automatic logic [31:0] max_pos_code(input int data_width);
        return (32'd1 << (data_width - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] min_neg_code(input int data_width);
        return 32'd1 << (data_width - 1);
    endfunction

endpackage

// File: rtl/sample_magnitude.sv
// ---------------------------------------------------------------------------
// sample_magnitude
// Registered first stage of the meter: absolute value with saturation of the
// most-negative code, plus full-scale (clip) detection.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear_i     : synchronous flush of the stage valid flag
//   sample_i    : signed input sample, captured when valid_i=1
//   valid_i     : input strobe
//   mag_o       : |sample| in MagWidth unsigned bits
//   clip_o      : sample was a full-scale code (qualify with valid_o)
//   valid_o     : stage output valid
// ---------------------------------------------------------------------------
module sample_magnitude
    import meter_pkg::*;
#(
    parameter int DataWidth = 12,
    parameter int MagWidth  = mag_width(DataWidth)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_i,
    input  logic signed [DataWidth-1:0] sample_i,
    input  logic                        valid_i,
    output logic        [MagWidth-1:0]  mag_o,
    output logic                        clip_o,
    output logic                        valid_o
);

    localparam logic [DataWidth-1:0] MaxPos = DataWidth'(max_pos_code(DataWidth));
    localparam logic [DataWidth-1:0] MinNeg = DataWidth'(min_neg_code(DataWidth));

    logic [DataWidth-1:0] negated;
    logic [MagWidth-1:0]  mag_d;
    logic                 clip_d;
    logic [MagWidth-1:0]  mag_q;
    logic                 clip_q;
    logic                 valid_q;

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        negated = -sample_i;
        mag_d   = sample_i[MagWidth-1:0];
        if (sample_i == MinNeg) begin
            // -2^(N-1) has no positive counterpart in N-1 bits.
            mag_d = '1;
        end else if (sample_i[DataWidth-1]) begin
            mag_d = negated[MagWidth-1:0];
        end
        clip_d = (sample_i == MaxPos) || (sample_i == MinNeg);
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_q   <= '0;
            clip_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                mag_q  <= mag_d;
                clip_q <= clip_d;
            end
        end
    end

    assign mag_o   = mag_q;
    assign clip_o  = clip_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/peak_level_meter.sv
// ---------------------------------------------------------------------------
// peak_level_meter
// Streaming peak meter: held, decaying peak magnitude of the filtered sample
// stream, plus sticky clip flag and saturating clip counter. Two-stage
// pipeline, one sample per cycle, never stalls.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   sampleIn     : signed filtered sample, used when sampleValid=1
//   sampleValid  : one-cycle sample strobe
//   clear        : synchronous clear of all meter state and the pipeline
//   peak         : unsigned held/decayed peak magnitude
//   peakValid    : pulses when peak has been updated for a sample
//   clipFlag     : sticky full-scale indication
//   clipCount    : saturating count of full-scale samples
// ---------------------------------------------------------------------------
module peak_level_meter
    import meter_pkg::*;
#(
    parameter int DataWidth      = 12,
    parameter int HoldSamples    = 4,
    parameter int DecayShift     = 3,
    parameter int ClipCountWidth = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [DataWidth-1:0] sampleIn,
    input  logic                        sampleValid,
    input  logic                        clear,
    output logic        [DataWidth-2:0] peak,
    output logic                        peakValid,
    output logic                        clipFlag,
    output logic   [ClipCountWidth-1:0] clipCount
);

    localparam int MagWidth  = mag_width(DataWidth);
    localparam int HoldWidth = (HoldSamples < 1) ? 1 : $clog2(HoldSamples + 1);

    logic [MagWidth-1:0] s1_mag;
    logic                s1_clip;
    logic                s1_valid;

    sample_magnitude #(
        .DataWidth (DataWidth),
        .MagWidth  (MagWidth)
    ) u_stage1 (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (clear),
        .sample_i (sampleIn),
        .valid_i  (sampleValid),
        .mag_o    (s1_mag),
        .clip_o   (s1_clip),
        .valid_o  (s1_valid)
    );

    meter_state_e              state_q, state_d;
    logic [MagWidth-1:0]       peak_q, peak_d;
    logic [HoldWidth-1:0]      hold_q, hold_d;
    logic                      peak_valid_q, peak_valid_d;
    logic                      clip_flag_q, clip_flag_d;
    logic [ClipCountWidth-1:0] clip_count_q, clip_count_d;
    logic [MagWidth-1:0]       decay_step;
    logic [MagWidth-1:0]       decayed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            peak_q       <= '0;
            hold_q       <= '0;
            peak_valid_q <= 1'b0;
            clip_flag_q  <= 1'b0;
            clip_count_q <= '0;
        end else begin
            state_q      <= state_d;
            peak_q       <= peak_d;
            hold_q       <= hold_d;
            peak_valid_q <= peak_valid_d;
            clip_flag_q  <= clip_flag_d;
            clip_count_q <= clip_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        peak_d       = peak_q;
        hold_d       = hold_q;
        peak_valid_d = 1'b0;
        clip_flag_d  = clip_flag_q;
        clip_count_d = clip_count_q;

        // Step is at least 1 so small peaks still reach zero; only used in
        // DECAY where peak_q > 0, so the subtraction cannot underflow.
        decay_step = peak_q >> DecayShift;
        if (decay_step == '0) begin
            decay_step = MagWidth'(1);
        end
        decayed = peak_q - decay_step;

        if (clear) begin
            state_d      = IDLE;
            peak_d       = '0;
            hold_d       = '0;
            clip_flag_d  = 1'b0;
            clip_count_d = '0;
        end else if (s1_valid) begin
            peak_valid_d = 1'b1;

            if (s1_clip) begin
                clip_flag_d = 1'b1;
                if (clip_count_q != '1) begin
                    clip_count_d = clip_count_q + 1'b1;
                end
            end

            // Equal magnitudes also win, which re-arms the hold period.
            if ((s1_mag >= peak_q) && (s1_mag != '0)) begin
                peak_d  = s1_mag;
                hold_d  = HoldWidth'(HoldSamples);
                state_d = (HoldSamples == 0) ? DECAY : HOLD;
            end else begin
                unique case (state_q)
                    HOLD: begin
                        hold_d = hold_q - 1'b1;
                        if (hold_q == HoldWidth'(1)) begin
                            state_d = DECAY;
                        end
                    end
                    DECAY: begin
                        peak_d = (decayed > s1_mag) ? decayed : s1_mag;
                        if (peak_d == '0) begin
                            state_d = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign peak      = peak_q;
    assign peakValid = peak_valid_q;
    assign clipFlag  = clip_flag_q;
    assign clipCount = clip_count_q;

endmodule

// File: tb/tb_peak_level_meter.sv
// ---------------------------------------------------------------------------
// tb_peak_level_meter
// Directed bench for peak_level_meter with DataWidth=12, HoldSamples=4,
// DecayShift=3, ClipCountWidth=8. Inputs change on the falling edge, the DUT
// samples on the rising edge, outputs are checked on the next falling edge.
// ---------------------------------------------------------------------------
module tb_peak_level_meter;

    logic               clk;
    logic               reset;
    logic signed [11:0] sampleIn;
    logic               sampleValid;
    logic               clear;
    logic        [10:0] peak;
    logic               peakValid;
    logic               clipFlag;
    logic        [7:0]  clipCount;

    int checks   = 0;
    int failures = 0;

    peak_level_meter #(
        .DataWidth      (12),
        .HoldSamples    (4),
        .DecayShift     (3),
        .ClipCountWidth (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sampleIn    (sampleIn),
        .sampleValid (sampleValid),
        .clear       (clear),
        .peak        (peak),
        .peakValid   (peakValid),
        .clipFlag    (clipFlag),
        .clipCount   (clipCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs from a falling edge up to the next one.
    task automatic step(input logic v, input int d, input logic c);
        sampleValid = v;
        sampleIn    = 12'(d);
        clear       = c;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++; if (peak !== 11'd0) begin failures++; $display("FAIL reset_peak: got %0d expected 0", peak); end
        checks++; if (peakValid !== 1'b0) begin failures++; $display("FAIL reset_peakValid: got %0b expected 0", peakValid); end
        checks++; if (clipFlag !== 1'b0) begin failures++; $display("FAIL reset_clipFlag: got %0b expected 0", clipFlag); end
        checks++; if (clipCount !== 8'd0) begin failures++; $display("FAIL reset_clipCount: got %0d expected 0", clipCount); end
        reset = 1'b0;
        step(0, 0, 0);
        checks++; if (peakValid !== 1'b0) begin failures++; $display("FAIL reset_idle_pv: got %0b expected 0", peakValid); end
    endtask

    task automatic test_back_to_back;
        step(1, 1000, 0);
        checks++; if (peakValid !== 1'b0) begin failures++; $display("FAIL b2b_latency1: got pv=%0b expected 0", peakValid); end
        step(1, -1500, 0);
        checks++; if (peakValid !== 1'b1 || peak !== 11'd1000) begin failures++; $display("FAIL b2b_first: got pv=%0b peak=%0d expected pv=1 peak=1000", peakValid, peak); end
        step(0, 0, 0);
        checks++; if (peakValid !== 1'b1 || peak !== 11'd1500) begin failures++; $display("FAIL b2b_second: got pv=%0b peak=%0d expected pv=1 peak=1500", peakValid, peak); end
        step(0, 0, 0);
        checks++; if (peakValid !== 1'b0) begin failures++; $display("FAIL b2b_no_extra_pv: got %0b expected 0", peakValid); end
    endtask

    task automatic test_hold_decay;
        int exp_peak [6] = '{1500, 1500, 1500, 1500, 1313, 1149};
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
            checks++;
            if (peakValid !== 1'b1 || peak !== 11'(exp_peak[i])) begin
                failures++;
                $display("FAIL hold_decay[%0d]: got pv=%0b peak=%0d expected pv=1 peak=%0d", i, peakValid, peak, exp_peak[i]);
            end
        end
    endtask

    task automatic test_clip;
        step(1, -2048, 0);
        step(0, 0, 0);
        checks++; if (peak !== 11'd2047 || clipFlag !== 1'b1 || clipCount !== 8'd1) begin failures++; $display("FAIL clip_minneg: got peak=%0d flag=%0b count=%0d expected 2047 1 1", peak, clipFlag, clipCount); end
        // Let part of the hold elapse so the next equal sample must re-arm it.
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 2047, 0);
        step(0, 0, 0);
        checks++; if (peak !== 11'd2047 || clipCount !== 8'd2) begin failures++; $display("FAIL clip_maxpos: got peak=%0d count=%0d expected 2047 2", peak, clipCount); end
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(0, 0, 0);
        checks++; if (peak !== 11'd2047) begin failures++; $display("FAIL clip_hold_reload: got peak=%0d expected 2047", peak); end
        step(1, 0, 0);
        step(0, 0, 0);
        checks++; if (peak !== 11'd1792) begin failures++; $display("FAIL clip_decay_after_hold: got peak=%0d expected 1792", peak); end
        for (int i = 0; i < 300; i++) step(1, (i % 2) ? 2047 : -2048, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        checks++; if (clipCount !== 8'd255 || clipFlag !== 1'b1) begin failures++; $display("FAIL clip_saturate: got count=%0d flag=%0b expected 255 1", clipCount, clipFlag); end
        checks++; if (peak !== 11'd2047) begin failures++; $display("FAIL clip_saturate_peak: got %0d expected 2047", peak); end
    endtask

    task automatic test_decay_to_zero;
        int exp_peak [7] = '{4, 3, 2, 1, 0, 0, 0};
        step(0, 0, 1);
        step(0, 0, 0);
        checks++; if (peak !== 11'd0 || clipFlag !== 1'b0 || clipCount !== 8'd0) begin failures++; $display("FAIL dz_clear: got peak=%0d flag=%0b count=%0d expected 0 0 0", peak, clipFlag, clipCount); end
        step(1, 5, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(0, 0, 0);
        checks++; if (peak !== 11'd5) begin failures++; $display("FAIL dz_held: got peak=%0d expected 5", peak); end
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
            checks++;
            if (peakValid !== 1'b1 || peak !== 11'(exp_peak[i])) begin
                failures++;
                $display("FAIL dz_step[%0d]: got pv=%0b peak=%0d expected pv=1 peak=%0d", i, peakValid, peak, exp_peak[i]);
            end
        end
        // From IDLE a small sample must be taken immediately.
        step(1, -3, 0);
        step(0, 0, 0);
        checks++; if (peak !== 11'd3) begin failures++; $display("FAIL dz_restart: got peak=%0d expected 3", peak); end
    endtask

    task automatic test_clear;
        step(1, -2048, 0);
        step(0, 0, 0);
        step(1, 1000, 0);
        step(1, 1800, 1);
        checks++; if (peak !== 11'd0 || clipFlag !== 1'b0 || clipCount !== 8'd0 || peakValid !== 1'b0) begin failures++; $display("FAIL clear_state: got peak=%0d flag=%0b count=%0d pv=%0b expected all 0", peak, clipFlag, clipCount, peakValid); end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0);
            checks++; if (peakValid !== 1'b0 || peak !== 11'd0) begin failures++; $display("FAIL clear_flush[%0d]: got pv=%0b peak=%0d expected 0 0", i, peakValid, peak); end
        end
        step(1, 200, 0);
        step(0, 0, 0);
        checks++; if (peakValid !== 1'b1 || peak !== 11'd200) begin failures++; $display("FAIL clear_next: got pv=%0b peak=%0d expected pv=1 peak=200", peakValid, peak); end
    endtask

    task automatic test_reset_mid_pipeline;
        step(1, -2048, 0);
        step(1, 700, 0);
        // -2048 is now in stage 2 (peak 2047); 700 sits in stage 1.
        sampleValid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (peak !== 11'd0 || peakValid !== 1'b0 || clipFlag !== 1'b0 || clipCount !== 8'd0) begin failures++; $display("FAIL rst_mid_async: got peak=%0d pv=%0b flag=%0b count=%0d expected all 0", peak, peakValid, clipFlag, clipCount); end
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0);
            checks++; if (peakValid !== 1'b0 || peak !== 11'd0) begin failures++; $display("FAIL rst_mid_flush[%0d]: got pv=%0b peak=%0d expected 0 0", i, peakValid, peak); end
        end
        step(1, 300, 0);
        step(0, 0, 0);
        checks++; if (peakValid !== 1'b1 || peak !== 11'd300) begin failures++; $display("FAIL rst_mid_first: got pv=%0b peak=%0d expected pv=1 peak=300", peakValid, peak); end
    endtask

    initial begin
        reset       = 1'b1;
        sampleValid = 1'b0;
        sampleIn    = '0;
        clear       = 1'b0;
        test_reset();
        test_back_to_back();
        test_hold_decay();
        test_clip();
        test_decay_to_zero();
        test_clear();
        test_reset_mid_pipeline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
